// File: rtl/ieee754_pkg.sv
// Shared definitions for the IEEE-754 normaliser: default widths, a
// constant clog2 helper and the canonical pipeline payload layout.
package ieee754_pkg;

    localparam int FP32_MANT_W   = 23;
    localparam int FP32_PROD_W   = 48;
    localparam int DEFAULT_TAG_W = 8;

    // Ceiling log2, usable in parameter and width expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Payload carried between shift layers at the FP32 product width.
    // Modules built with other widths declare the same layout locally.
    typedef struct packed {
        logic [FP32_PROD_W-1:0]        src;
        logic [clog2(FP32_PROD_W)-1:0] shifted;
        logic                          zero;
        logic                          sticky;
        logic [DEFAULT_TAG_W-1:0]      tag;
    } norm_payload_t;

endpackage

// File: rtl/ieee754_norm_stage.sv
// One registered shift layer of the leading-one normaliser. It shifts
// left by 2^CNT_BIT when the top 2^CNT_BIT bits are zero, records that
// decision in count bit CNT_BIT, and advances only while en is high.
// With IEEE754_NORMALIZE_STICKY_EN defined it also folds into sticky
// every bit that the remaining smaller layers can no longer lift above
// the guard position.
module ieee754_norm_stage
    import ieee754_pkg::*;
#(
    parameter int IN_W    = FP32_PROD_W,
    parameter int MANT_W  = FP32_MANT_W,
    parameter int TAG_W   = DEFAULT_TAG_W,
    parameter int SHIFT_W = clog2(FP32_PROD_W),
    parameter int CNT_BIT = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               in_valid,
    input  logic [IN_W-1:0]    in_src,
    input  logic [SHIFT_W-1:0] in_shifted,
    input  logic               in_zero,
    input  logic               in_sticky,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    output logic [IN_W-1:0]    out_src,
    output logic [SHIFT_W-1:0] out_shifted,
    output logic               out_zero,
    output logic               out_sticky,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int SHIFT_AMT  = 1 << CNT_BIT;
    localparam int STICKY_LIM = IN_W - 1 - MANT_W - SHIFT_AMT;

    typedef struct packed {
        logic [IN_W-1:0]    src;
        logic [SHIFT_W-1:0] shifted;
        logic               zero;
        logic               sticky;
        logic [TAG_W-1:0]   tag;
    } payload_t;

    logic               do_shift;
    logic [IN_W-1:0]    next_src;
    logic [SHIFT_W-1:0] next_shifted;
    logic               spill;
    logic               valid_q;
    payload_t           stage_q;

    // Decide this layer's shift; a zero input never shifts so its count stays 0.
    always_comb begin
        do_shift              = !in_zero && (in_src[IN_W-1 -: SHIFT_AMT] == '0);
        next_src              = do_shift ? (in_src << SHIFT_AMT) : in_src;
        next_shifted          = in_shifted;
        next_shifted[CNT_BIT] = do_shift;
    end

    generate
        if (STICKY_LIM > 0) begin : g_spill
            assign spill = |next_src[STICKY_LIM-1:0];
        end else begin : g_no_spill
            assign spill = 1'b0;
        end
    endgenerate

    // Stage register: everything, bubbles included, moves only on en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            stage_q <= '0;
        end else if (en) begin
            valid_q         <= in_valid;
            stage_q.src     <= next_src;
            stage_q.shifted <= next_shifted;
            stage_q.zero    <= in_zero;
            stage_q.tag     <= in_tag;
`ifdef IEEE754_NORMALIZE_STICKY_EN
            stage_q.sticky  <= in_sticky | spill;
`else
            stage_q.sticky  <= 1'b0;
`endif
        end
    end

`ifndef IEEE754_NORMALIZE_STICKY_EN
    logic unused_sticky;
    assign unused_sticky = in_sticky | spill;
`endif

    assign out_valid   = valid_q;
    assign out_src     = stage_q.src;
    assign out_shifted = stage_q.shifted;
    assign out_zero    = stage_q.zero;
    assign out_sticky  = stage_q.sticky;
    assign out_tag     = stage_q.tag;

endmodule

// File: rtl/ieee754_normalize_pipe.sv
// Pipelined leading-one normaliser: SHIFT_W shift layers, largest first,
// with a single global advance enable for valid/ready flow control.
// Optional macro IEEE754_NORMALIZE_STICKY_EN enables guard/sticky outputs;
// without it both are tied to 0.
module ieee754_normalize_pipe
    import ieee754_pkg::*;
#(
    parameter int IN_W    = FP32_PROD_W,
    parameter int MANT_W  = FP32_MANT_W,
    parameter int TAG_W   = DEFAULT_TAG_W,
    parameter int SHIFT_W = clog2(IN_W)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_src,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MANT_W-1:0]  out_result,
    output logic [SHIFT_W-1:0] out_shifted,
    output logic               out_zero,
    output logic               out_guard,
    output logic               out_sticky,
    output logic [TAG_W-1:0]   out_tag
);

    logic               adv;
    logic               valid_c   [0:SHIFT_W];
    logic [IN_W-1:0]    src_c     [0:SHIFT_W];
    logic [SHIFT_W-1:0] shifted_c [0:SHIFT_W];
    logic               zero_c    [0:SHIFT_W];
    logic               sticky_c  [0:SHIFT_W];
    logic [TAG_W-1:0]   tag_c     [0:SHIFT_W];

    // The pipe moves whenever the output slot is empty or being drained.
    assign adv      = !valid_c[SHIFT_W] || out_ready;
    assign in_ready = adv;

    assign valid_c[0]   = in_valid;
    assign src_c[0]     = in_src;
    assign shifted_c[0] = '0;
    assign zero_c[0]    = ~|in_src;
    assign sticky_c[0]  = 1'b0;
    assign tag_c[0]     = in_tag;

    generate
        for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
            ieee754_norm_stage #(
                .IN_W    (IN_W),
                .MANT_W  (MANT_W),
                .TAG_W   (TAG_W),
                .SHIFT_W (SHIFT_W),
                .CNT_BIT (SHIFT_W - 1 - k)
            ) u_stage (
                .clk         (clk),
                .reset       (reset),
                .en          (adv),
                .in_valid    (valid_c[k]),
                .in_src      (src_c[k]),
                .in_shifted  (shifted_c[k]),
                .in_zero     (zero_c[k]),
                .in_sticky   (sticky_c[k]),
                .in_tag      (tag_c[k]),
                .out_valid   (valid_c[k+1]),
                .out_src     (src_c[k+1]),
                .out_shifted (shifted_c[k+1]),
                .out_zero    (zero_c[k+1]),
                .out_sticky  (sticky_c[k+1]),
                .out_tag     (tag_c[k+1])
            );
        end
    endgenerate

    assign out_valid   = valid_c[SHIFT_W];
    assign out_result  = src_c[SHIFT_W][IN_W-2 -: MANT_W];
    assign out_shifted = shifted_c[SHIFT_W];
    assign out_zero    = zero_c[SHIFT_W];
    assign out_tag     = tag_c[SHIFT_W];

`ifdef IEEE754_NORMALIZE_STICKY_EN
    assign out_guard  = src_c[SHIFT_W][IN_W-2-MANT_W];
    assign out_sticky = sticky_c[SHIFT_W];
`else
    assign out_guard  = 1'b0;
    assign out_sticky = 1'b0;
`endif

    logic unused_final;
    assign unused_final = ^{src_c[SHIFT_W], sticky_c[SHIFT_W]};

endmodule

// File: tb/tb_ieee754_normalize_pipe.sv
// Scoreboard bench for ieee754_normalize_pipe at default widths.
`timescale 1ns/1ps
module tb_ieee754_normalize_pipe;

    localparam int IN_W    = 48;
    localparam int MANT_W  = 23;
    localparam int TAG_W   = 8;
    localparam int SHIFT_W = 6;
`ifdef IEEE754_NORMALIZE_STICKY_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    in_src;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [MANT_W-1:0]  out_result;
    logic [SHIFT_W-1:0] out_shifted;
    logic               out_zero;
    logic               out_guard;
    logic               out_sticky;
    logic [TAG_W-1:0]   out_tag;

    always #5 clk = ~clk;

    ieee754_normalize_pipe dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_src      (in_src),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_shifted (out_shifted),
        .out_zero    (out_zero),
        .out_guard   (out_guard),
        .out_sticky  (out_sticky),
        .out_tag     (out_tag)
    );

    typedef struct {
        logic [MANT_W-1:0]  result;
        logic [SHIFT_W-1:0] shifted;
        logic               zero;
        logic               guard;
        logic               sticky;
        logic [TAG_W-1:0]   tag;
    } exp_t;

    typedef struct {
        logic [IN_W-1:0]    src;
        logic [MANT_W-1:0]  result;
        logic [SHIFT_W-1:0] shifted;
        logic               zero;
        logic               guard;
        logic               sticky;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[10];
    int   compared   = 0;
    int   mismatched = 0;
    int   popped     = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    // Drive one beat, hold it until accepted, push its expectation.
    task automatic applyStimulus(input vec_t v, input logic [TAG_W-1:0] tag);
        exp_t e;
        bit   accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_src   = v.src;
        in_tag   = tag;
        for (int i = 0; i < 40 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.result  = v.result;
                e.shifted = v.shifted;
                e.zero    = v.zero;
                e.guard   = v.guard & STICKY_ON;
                e.sticky  = v.sticky & STICKY_ON;
                e.tag     = tag;
                sb_q.push_back(e);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL accept_timeout: got no accept, expected accept for tag 0x%0h", tag);
        end
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput(name, 64'(sb_q.size()), 64'd0);
    endtask

    // Monitor: compare every consumed beat and check stall behaviour.
    logic               stall_prev = 1'b0;
    logic [MANT_W-1:0]  hold_result;
    logic [SHIFT_W-1:0] hold_shifted;
    logic [TAG_W-1:0]   hold_tag;
    logic               hold_valid;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checkOutput("hold_valid",   64'(out_valid),   64'(hold_valid));
                checkOutput("hold_result",  64'(out_result),  64'(hold_result));
                checkOutput("hold_shifted", 64'(out_shifted), 64'(hold_shifted));
                checkOutput("hold_tag",     64'(out_tag),     64'(hold_tag));
            end
            if (out_valid && !out_ready) begin
                checkOutput("in_ready_stall", 64'(in_ready), 64'd0);
            end
            stall_prev   = out_valid && !out_ready;
            hold_valid   = out_valid;
            hold_result  = out_result;
            hold_shifted = out_shifted;
            hold_tag     = out_tag;
            if (out_valid && out_ready) begin
                popped++;
                if (sb_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_beat: got tag 0x%0h, expected no beat", out_tag);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("tag",     64'(out_tag),     64'(e.tag));
                    checkOutput("result",  64'(out_result),  64'(e.result));
                    checkOutput("shifted", 64'(out_shifted), 64'(e.shifted));
                    checkOutput("zero",    64'(out_zero),    64'(e.zero));
                    checkOutput("guard",   64'(out_guard),   64'(e.guard));
                    checkOutput("sticky",  64'(out_sticky),  64'(e.sticky));
                end
            end
        end
    end

    initial begin
        int pop_base;
        int stale;
        int lat;

        //             src                  result        sh     zero  guard sticky
        vecs[0] = '{48'h8000_0000_0000, 23'h000000, 6'd0,  1'b0, 1'b0, 1'b0};
        vecs[1] = '{48'h0000_0000_0001, 23'h000000, 6'd47, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{48'h0000_0000_0000, 23'h000000, 6'd0,  1'b1, 1'b0, 1'b0};
        vecs[3] = '{48'h0180_0000_0001, 23'h400000, 6'd7,  1'b0, 1'b0, 1'b1};
        vecs[4] = '{48'h0000_0180_0001, 23'h400000, 6'd23, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{48'hFFFF_FFFF_FFFF, 23'h7FFFFF, 6'd0,  1'b0, 1'b1, 1'b1};
        vecs[6] = '{48'h0000_0000_0003, 23'h400000, 6'd46, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{48'h5555_5555_5555, 23'h2AAAAA, 6'd1,  1'b0, 1'b1, 1'b1};
        vecs[8] = '{48'h0000_0000_C001, 23'h400100, 6'd32, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{48'h0000_8000_0001, 23'h000000, 6'd16, 1'b0, 1'b0, 1'b1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_src    = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        #2;
        checkOutput("rst_out_valid",   64'(out_valid),   64'd0);
        checkOutput("rst_out_result",  64'(out_result),  64'd0);
        checkOutput("rst_out_shifted", 64'(out_shifted), 64'd0);
        checkOutput("rst_out_zero",    64'(out_zero),    64'd0);
        checkOutput("rst_out_guard",   64'(out_guard),   64'd0);
        checkOutput("rst_out_sticky",  64'(out_sticky),  64'd0);
        checkOutput("rst_out_tag",     64'(out_tag),     64'd0);
        checkOutput("rst_in_ready",    64'(in_ready),    64'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] directed vectors");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], TAG_W'(8'hA0 + i));
        end
        waitDrain("directed_drain");

        $display("[TB] backpressure");
        pop_base = popped;
        @(posedge clk);
        #1;
        fork
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i % 10], TAG_W'(i));
        end
        waitDrain("bp_drain");
        checkOutput("bp_beat_count", 64'(popped - pop_base), 64'd8);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[5], TAG_W'(8'h50 + i));
        end
        checkOutput("pre_reset_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_valid",  64'(out_valid),  64'd0);
        checkOutput("mid_rst_result", 64'(out_result), 64'd0);
        checkOutput("mid_rst_tag",    64'(out_tag),    64'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checkOutput("no_stale_beat", 64'(stale), 64'd0);

        @(posedge clk);
        #1;
        applyStimulus(vecs[3], 8'h77);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("post_reset_latency", 64'(lat), 64'd6);
        waitDrain("final_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
